// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
//   Shared constants and types for the FP16 stream accumulator.
//   FP_BITS/E_BITS/M_BITS describe the FP16 word (M_BITS includes hidden bit),
//   FP_CNT_W is the default sample-counter width, FP_ZERO is +0, EXP_MAX is the
//   all-ones exponent used for Inf/NaN, accum_state_t is the accumulator FSM.
// ----------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_BITS  = 16;
  localparam int E_BITS   = 5;
  localparam int M_BITS   = 11;
  localparam int FP_CNT_W = 8;

  localparam logic [FP_BITS-1:0] FP_ZERO = 16'h0000;
  localparam logic [E_BITS-1:0]  EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } accum_state_t;

endpackage

// File: rtl/fp_class.sv
// ----------------------------------------------------------------------------
// fp_class
//   Combinational classifier on an FP exponent field.
//   Ports:
//     exp_i       in  EW  exponent field of an FP word
//     is_inf_nan  out 1   exponent is all-ones (Inf or NaN)
// ----------------------------------------------------------------------------
module fp_class
  import fp_pkg::*;
#(
  parameter int EW = E_BITS
) (
  input  logic [EW-1:0] exp_i,
  output logic          is_inf_nan
);

  assign is_inf_nan = (exp_i == {EW{1'b1}});

endmodule

// File: rtl/fp_accum.sv
// ----------------------------------------------------------------------------
// fp_accum
//   Sequential FP16 stream accumulator driving an external combinational adder.
//   The running sum is presented as add_a, the incoming sample as add_b, and
//   the adder result add_y is registered as the new sum on each accepted
//   sample. After len samples the sum is offered on a valid/ready port.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start, len          begin accumulation of len samples (IDLE only)
//     in_valid/in_ready   sample handshake, in_data = FP16 sample
//     add_a/add_b/add_y   external adder operands and result
//     out_valid/out_ready result handshake, out_data = final sum
//     flag_inf            sticky: a sample or partial sum had all-ones exponent
//     busy                FSM is not IDLE
// ----------------------------------------------------------------------------
module fp_accum #(
  parameter int BITS   = 16,
  parameter int E_BITS = 5,
  parameter int M_BITS = 11,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_data,
  output logic [BITS-1:0]  add_a,
  output logic [BITS-1:0]  add_b,
  input  logic [BITS-1:0]  add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_data,
  output logic             flag_inf,
  output logic             busy
);

  import fp_pkg::*;

  // Exponent field sits just above the stored fraction bits.
  localparam int EXP_LSB = M_BITS - 1;

  accum_state_t     state_q;
  logic [BITS-1:0]  acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             flag_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             in_inf_s;
  logic             y_inf_s;
  logic             accept_s;
  logic             last_s;

  fp_class #(.EW(E_BITS)) u_class_in (
    .exp_i      (in_data[EXP_LSB +: E_BITS]),
    .is_inf_nan (in_inf_s)
  );

  fp_class #(.EW(E_BITS)) u_class_y (
    .exp_i      (add_y[EXP_LSB +: E_BITS]),
    .is_inf_nan (y_inf_s)
  );

  // in_ready_q is only set while in RUN, so this is the RUN-state accept.
  assign accept_s = in_valid & in_ready_q;
  assign last_s   = (cnt_q == (len_q - {{(CNT_W-1){1'b0}}, 1'b1}));

  // Accumulator FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= FP_ZERO;
      cnt_q       <= '0;
      len_q       <= '0;
      flag_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            acc_q  <= FP_ZERO;
            cnt_q  <= '0;
            flag_q <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              // Empty stream: the result is +0 straight away.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept_s) begin
            acc_q  <= add_y;
            cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            flag_q <= flag_q | in_inf_s | y_inf_s;
            if (last_s) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // A start arriving with out_ready is dropped; IDLE sees it next cycle at earliest.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign flag_inf  = flag_q;
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_fp_accum.sv
module tb_fp_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flag_inf;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference FP16 adder, round-to-nearest-even, computed on exact integers
  // in units of 2^-24 (the smallest subnormal).
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, p, e, sh;
    longint va, vb, s, m, q, rem, half;
    logic   rs;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 10'd0) || (eb == 31 && b[9:0] != 10'd0)) return 16'h7E00;
    if (ea == 31 && eb == 31) return (a[15] == b[15]) ? a : 16'h7E00;
    if (ea == 31) return a;
    if (eb == 31) return b;
    va = (ea == 0) ? longint'(a[9:0]) : (longint'(1024 + int'(a[9:0])) <<< (ea - 1));
    vb = (eb == 0) ? longint'(b[9:0]) : (longint'(1024 + int'(b[9:0])) <<< (eb - 1));
    if (a[15]) va = -va;
    if (b[15]) vb = -vb;
    s = va + vb;
    if (s == 0) return {a[15] & b[15], 15'h0000};
    rs = (s < 0);
    m  = rs ? -s : s;
    p  = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    if (p < 10) return {rs, 5'd0, m[9:0]};
    e    = p - 9;
    sh   = p - 10;
    q    = m >>> sh;
    rem  = m - (q <<< sh);
    half = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
    if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {rs, 5'h1F, 10'h000};
    return {rs, e[4:0], q[9:0]};
  endfunction

  always_comb add_y = fp16_add(add_a, add_b);

  fp_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flag_inf  (flag_inf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_special(input logic [15:0] v);
    return (v[14:10] == 5'h1F);
  endfunction

  // One complete accumulation: start, feed samples (with gaps), hold DONE, retire.
  task automatic run(input int n, input logic [15:0] smp[$], input int min_gap,
                     input int max_gap, input int hold);
    logic [15:0] sum;
    logic [15:0] partial;
    logic        flg;
    sum = 16'h0000;
    flg = 1'b0;
    foreach (smp[i]) begin
      flg = flg | is_special(smp[i]);
      sum = fp16_add(sum, smp[i]);
      flg = flg | is_special(sum);
    end
    partial = 16'h0000;
    start = 1'b1;
    len   = n[7:0];
    step();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("flag_cleared_on_start", {31'd0, flag_inf}, 32'd0);
    if (n == 0) begin
      chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
    end else begin
      chk("run_in_ready", {31'd0, in_ready}, 32'd1);
      chk("run_out_valid", {31'd0, out_valid}, 32'd0);
    end
    foreach (smp[i]) begin
      repeat ($urandom_range(max_gap, min_gap)) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        step();
        chk("gap_hold_add_a", {16'd0, add_a}, {16'd0, partial});
        chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b1;
      in_data  = smp[i];
      #1;
      chk("add_b_passthru", {16'd0, add_b}, {16'd0, smp[i]});
      chk("add_a_partial", {16'd0, add_a}, {16'd0, partial});
      step();
      partial = fp16_add(partial, smp[i]);
      in_valid = 1'b0;
    end
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_out_data", {16'd0, out_data}, {16'd0, sum});
    chk("done_flag_inf", {31'd0, flag_inf}, {31'd0, flg});
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h == 0);
      len       = 8'd3;
      step();
      start = 1'b0;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", {16'd0, out_data}, {16'd0, sum});
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd4;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("retire_out_valid", {31'd0, out_valid}, 32'd0);
    chk("retire_busy", {31'd0, busy}, 32'd0);
    step();
    chk("coincident_start_ignored", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] q[$];
    int          n;
    logic [15:0] v;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_flag", {31'd0, flag_inf}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1.0 + 2.0 back-to-back
    q = '{16'h3C00, 16'h4000};
    run(2, q, 0, 0, 0);
    chk("sum_1p2_is_3", {16'd0, fp16_add(fp16_add(16'h0000, 16'h3C00), 16'h4000)}, 32'h4200);

    // 1 - 1 + 0.5 with gaps
    q = '{16'h3C00, 16'hBC00, 16'h3800};
    run(3, q, 1, 3, 0);

    // empty stream
    q = {};
    run(0, q, 0, 0, 0);

    // infinity sample, then a normal run must clear the flag
    q = '{16'h7C00};
    run(1, q, 0, 0, 0);
    q = '{16'h3C00};
    run(1, q, 0, 0, 0);

    // DONE held for 5 cycles with a start pulse ignored
    q = '{16'h4400, 16'h4400};
    run(2, q, 0, 1, 5);

    // reset mid-RUN after 2 of 4 samples
    start = 1'b1;
    len   = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3C00;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      chk("postrst_no_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // randomized streams
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(12, 1));
      q = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(19, 0) == 0) v = 16'h7C00;
        else v = {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
        q.push_back(v);
      end
      run(n, q, 0, 2, int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
